uart_tx_buf: RTL

- Buffered 8N1 UART transmitter. It is the return path to the HC-01 Bluetooth module, the mirror of uart_rx on the same link.
- Game logic pushes bytes such as score or state reports through a valid/ready handshake. A FIFO decouples those bursts from the slow serial line.
- It runs on rgb_clk beside uart_rx, and tx_pin drives the HC-01 RX line.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/uart_tx_fifo.sv | 57 +++++
 rtl/uart_tx_buf.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
//   Shared types and helpers for the HC-01 UART link.
//   - tx_state_t : serializer FSM state encoding
//   - calc_cycle : clocks per bit from clock frequency (MHz) and baud rate
//   - FRAME_BITS : bits per 8N1 frame (start + 8 data + stop)
// ---------------------------------------------------------------------------
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int unsigned FRAME_BITS = 10;

  // Integer-truncated clocks per bit.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud);
    return (clk_fre * 1_000_000) / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Synchronous circular-buffer FIFO, 8 bits wide, DEPTH entries.
//   Pointers carry one extra wrap bit; full/empty come from comparing it.
//   Ports:
//     clk, rst_n   : clock, asynchronous active-low reset (flushes FIFO)
//     push, din    : write request and data (ignored when full)
//     pop, dout    : read request and head-of-queue data (ignored when empty)
//     full, empty  : status from registered pointers
//     level        : number of stored entries
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Same index with differing wrap bits means the writer lapped the reader.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_tx_buf.sv
// ---------------------------------------------------------------------------
// uart_tx_buf
//   Buffered 8N1 UART transmitter (return path to the HC-01 module).
//   Bytes enter through a valid/ready handshake into uart_tx_fifo and are
//   serialized LSB first at CYCLE clocks per bit. Back-to-back frames are
//   sent without an idle gap when the FIFO still holds data.
//   Ports:
//     clk, rst_n     : clock, asynchronous active-low reset
//     tx_data        : byte to send, sampled on the accepting edge
//     tx_data_valid  : tx_data valid this cycle
//     tx_data_ready  : FIFO not full (registered state only)
//     tx_pin         : serial line, idles high
//     tx_busy        : FIFO non-empty or frame in progress
//     fifo_level     : bytes queued, excluding the one in flight
// ---------------------------------------------------------------------------
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRE   = 25,
  parameter int unsigned BAUD_RATE = 9600,
  parameter int unsigned DEPTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [7:0]                 tx_data,
  input  logic                       tx_data_valid,
  output logic                       tx_data_ready,
  output logic                       tx_pin,
  output logic                       tx_busy,
  output logic [$clog2(DEPTH):0]     fifo_level
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  tx_state_t   state;
  tx_state_t   state_next;
  logic [CW-1:0] baud_cnt;
  logic [CW-1:0] baud_next;
  logic [2:0]  bit_cnt;
  logic [2:0]  bit_cnt_next;
  logic [7:0]  shift;
  logic [7:0]  shift_next;
  logic        tx_pin_next;
  logic        busy_next;

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [7:0]  head;
  logic        bit_end;
  logic [LW-1:0] level_next;

  assign tx_data_ready = !full;
  assign push          = tx_data_valid && !full;
  assign bit_end       = (baud_cnt == CW'(CYCLE - 1));

  uart_tx_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (tx_data),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      tx_pin   <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      state    <= state_next;
      baud_cnt <= baud_next;
      bit_cnt  <= bit_cnt_next;
      shift    <= shift_next;
      tx_pin   <= tx_pin_next;
      tx_busy  <= busy_next;
    end
  end

  // Next-state logic; pop is asserted wherever a new frame is launched.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          state_next = START;
          pop        = 1'b1;
        end
      end
      START: begin
        if (bit_end) state_next = DATA;
      end
      DATA: begin
        if (bit_end && (bit_cnt == 3'd7)) state_next = STOP;
      end
      STOP: begin
        if (bit_end) begin
          if (!empty) begin
            state_next = START;
            pop        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Baud counter, bit counter and shift register.
  always_comb begin
    shift_next   = shift;
    bit_cnt_next = bit_cnt;
    if ((state_next == IDLE) || bit_end || pop) begin
      baud_next = '0;
    end else begin
      baud_next = baud_cnt + 1'b1;
    end
    if (pop) begin
      shift_next   = head;
      bit_cnt_next = '0;
    end else if ((state == DATA) && bit_end) begin
      shift_next   = {1'b0, shift[7:1]};
      bit_cnt_next = bit_cnt + 1'b1;
    end
  end

  // Outputs are registered from next-state values so tx_pin changes on the
  // same edge that enters a state, and tx_busy drops on the edge that ends
  // the last stop bit.
  always_comb begin
    level_next = fifo_level + LW'(push) - LW'(pop);
    unique case (state_next)
      START:   tx_pin_next = 1'b0;
      DATA:    tx_pin_next = shift_next[0];
      default: tx_pin_next = 1'b1;
    endcase
    busy_next = (state_next != IDLE) || (level_next != '0);
  end

endmodule
